fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0000, bubble instruction (sll $0,$0,0).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, synchronous reset, active-high.
- branch_stall, in, 1, decode reports an unresolved control-transfer instruction.
- dmem_stall, in, 1, decode reports a memory instruction in flight.
- redirect_valid, in, 1, execute has resolved a taken control transfer.
- redirect_pc, in, 32, target of the taken transfer.
- imem_req_valid, out, 1, instruction-memory request.
- imem_req_ready, in, 1, memory accepts the request.
- imem_addr, out, 32, request address (word-aligned).
- imem_resp_valid, in, 1, response data valid.
- imem_resp_data, in, 32, fetched instruction word.
- inst, out, 32, instruction to decode; registered.
- pc, out, 32, address of inst; registered.
- inst_valid, out, 1, inst is a real instruction (0 = bubble).

Function
REQ-003 The block SHALL implement an FSM with states REQ, WAIT, DISCARD and HALT.
REQ-004 The block SHALL hold a 32-bit fetch_pc register, and imem_addr SHALL equal fetch_pc at all times.
REQ-005 The block SHALL assert imem_req_valid only in REQ with stall=0, where stall = branch_stall | dmem_stall.
REQ-006 The handshake SHALL complete when imem_req_valid & imem_req_ready, and the FSM SHALL then move REQ->WAIT.
REQ-007 In REQ with ready=0, the FSM SHALL stay in REQ with imem_addr stable.
REQ-008 In WAIT on imem_resp_valid, the block SHALL:
- set inst <= imem_resp_data, pc <= fetch_pc, inst_valid <= 1;
- set fetch_pc <= fetch_pc + 4, with 32-bit wrap-around and no carry out;
- move WAIT->REQ.
REQ-009 In every cycle without a captured response, the block SHALL set inst <= NOP_INST and inst_valid <= 0, and SHALL leave pc unchanged.
REQ-010 Fetch-to-decode latency SHALL be at least 2 cycles: 1 request cycle with ready=1, then the response; inst appears on the edge that samples imem_resp_valid=1.
REQ-011 A stall SHALL block only new requests; a request already in WAIT SHALL complete and its response SHALL be delivered.
REQ-012 When stall deasserts, the block SHALL issue a request in the same cycle.
REQ-013 redirect_valid SHALL have priority over stall and response capture. In all states it SHALL set fetch_pc <= redirect_pc, inst <= NOP_INST and inst_valid <= 0.
REQ-014 Redirect state transitions SHALL be:
- in REQ or HALT: go to REQ;
- in WAIT with no response this cycle: go to DISCARD;
- in WAIT with a response this cycle: drop the response, go to REQ.
REQ-015 In DISCARD, the block SHALL drop the next response without capturing it and go to REQ. A second redirect in DISCARD SHALL update fetch_pc only.
REQ-016 If redirect_pc[1:0] != 0, the block SHALL force fetch_pc[1:0] to 0 and enter HALT. HALT SHALL issue no requests and SHALL be left only by reset or a valid redirect.
REQ-017 imem_resp_valid SHALL be ignored in REQ and HALT.

Reset
REQ-018 While rst=1 on a clock edge, the block SHALL set:
- fetch_pc = RESET_PC, state = REQ;
- inst = NOP_INST, pc = RESET_PC, inst_valid = 0.
REQ-019 rst SHALL have priority over all other inputs.
REQ-020 Reset during WAIT or DISCARD SHALL abandon the outstanding request. The first response after reset release SHALL be taken only for the new request; the memory SHALL drop the old one.
REQ-021 imem_req_valid SHALL be 0 during the rst=1 cycle and SHALL be 1 in the first cycle after release when stall=0.

Verification
REQ-022 Reset release, ready=1, 1-cycle response 0x24080005 -> imem_addr=0xBFC00000; then inst=0x24080005, pc=0xBFC00000, inst_valid=1; next imem_addr=0xBFC00004.
REQ-023 branch_stall=1 for 3 cycles while in REQ -> imem_req_valid=0 and inst=0 with inst_valid=0 for 3 cycles; request issued the cycle stall drops, same address.
REQ-024 Redirect to 0x80001000 while WAIT on 0xBFC00008 -> late response 0xDEADBEEF never appears on inst; next request addr=0x80001000.
REQ-025 Redirect and response in the same WAIT cycle -> response dropped, fetch_pc=redirect_pc, state REQ.
REQ-026 fetch_pc=0xFFFFFFFC, response received -> fetch_pc wraps to 0x00000000.
REQ-027 Redirect to 0x80000002 -> HALT, no requests; then a redirect to 0x80000010 resumes fetch at 0x80000010.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end. It issues one request at a time to
// instruction memory and hands each fetched word, with its address, to decode.
// Latency: request cycle with ready=1, then inst/pc/inst_valid are registered
//   on the edge that samples imem_resp_valid=1 (at least 2 cycles end to end).
// Backpressure: branch_stall/dmem_stall block new requests only, an in-flight
//   request still completes. imem_req_ready=0 holds the request and its address.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   branch_stall, dmem_stall      decode stall sources
//   redirect_valid, redirect_pc   taken control transfer from execute
//   imem_req_valid/ready, imem_addr               request channel
//   imem_resp_valid, imem_resp_data               response channel
//   inst, pc, inst_valid          registered instruction to decode
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_stall,
  input  logic        dmem_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_valid
);

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  // A misaligned redirect seen while a stale response is still outstanding
  // must not halt until that response is drained; otherwise the stale word
  // could be mistaken for the answer to the first request after resuming.
  logic        halt_pend;

  logic        stall;
  logic        misaligned;
  logic [31:0] redirect_aligned;
  logic        req_fire;

  assign stall            = branch_stall | dmem_stall;
  assign misaligned       = |redirect_pc[1:0];
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign imem_addr        = fetch_pc;

  // A redirect in REQ retargets fetch_pc on this edge, so no request may be
  // presented with the old address in that cycle.
  assign imem_req_valid = (state == ST_REQ) & ~stall & ~redirect_valid & ~rst;
  assign req_fire       = imem_req_valid & imem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_REQ;
      fetch_pc   <= RESET_PC;
      halt_pend  <= 1'b0;
      inst       <= NOP_INST;
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
    end else begin
      // Bubble by default; only a captured response overrides it.
      inst       <= NOP_INST;
      inst_valid <= 1'b0;

      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
        case (state)
          ST_WAIT: begin
            if (imem_resp_valid) begin
              // Response for the old path arrives with the redirect: drop it.
              state     <= misaligned ? ST_HALT : ST_REQ;
              halt_pend <= 1'b0;
            end else begin
              state     <= ST_DISCARD;
              halt_pend <= misaligned;
            end
          end
          ST_DISCARD: begin
            // Still owed one stale response; leave only once it has arrived.
            if (imem_resp_valid) begin
              state     <= misaligned ? ST_HALT : ST_REQ;
              halt_pend <= 1'b0;
            end else begin
              halt_pend <= misaligned;
            end
          end
          default: begin
            state     <= misaligned ? ST_HALT : ST_REQ;
            halt_pend <= 1'b0;
          end
        endcase
      end else begin
        case (state)
          ST_REQ: begin
            if (req_fire) state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (imem_resp_valid) begin
              inst       <= imem_resp_data;
              pc         <= fetch_pc;
              inst_valid <= 1'b1;
              fetch_pc   <= fetch_pc + 32'd4;
              state      <= ST_REQ;
            end
          end
          ST_DISCARD: begin
            if (imem_resp_valid) begin
              state     <= halt_pend ? ST_HALT : ST_REQ;
              halt_pend <= 1'b0;
            end
          end
          default: begin
            state <= ST_HALT;
          end
        endcase
      end
    end
  end

endmodule
